// File: rtl/pressure_ok_qualifier.sv
// pressure_ok_qualifier: synchronizes and debounces a raw pressure switch and qualifies it against the pump command.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges from a stable Pressure_Raw change to Pressure_OK_Signal.
// Backpressure: none; level in, level out, evaluated on every System_Clock edge.
//
// Ports:
//   System_Clock       - single clock, all state on the rising edge
//   System_Reset       - asynchronous, active-high reset
//   Pump_ON_Signal     - pump run command (synchronous)
//   Pressure_Raw       - raw pressure switch (asynchronous, noisy)
//   Fault_Clear        - fault acknowledge, honoured only with the pump off
//   Pressure_OK_Signal - registered, 1 only in OK
//   Pressure_Fault     - registered, 1 only in FAULT
//   State_Code         - IDLE=00, WAIT_RISE=01, OK=10, FAULT=11
module pressure_ok_qualifier #(
  parameter int SYNC_STAGES     = 2,    // >= 2
  parameter int DEBOUNCE_CYCLES = 16,   // >= 2
  parameter int TIMEOUT_CYCLES  = 1000, // > SYNC_STAGES + DEBOUNCE_CYCLES + 1
  parameter int CNT_W           = 16    // must hold TIMEOUT_CYCLES-1
) (
  input  logic       System_Clock,
  input  logic       System_Reset,
  input  logic       Pump_ON_Signal,
  input  logic       Pressure_Raw,
  input  logic       Fault_Clear,
  output logic       Pressure_OK_Signal,
  output logic       Pressure_Fault,
  output logic [1:0] State_Code
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMR_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_WAIT_RISE = 2'b01,
    ST_OK        = 2'b10,
    ST_FAULT     = 2'b11
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   db;
  logic [DB_W-1:0]        db_cnt;

  state_t                 state;
  state_t                 state_nxt;
  logic [CNT_W-1:0]       timer;
  logic [CNT_W-1:0]       timer_nxt;

  // Metastability chain; the oldest stage is the synchronized sample.
  always_ff @(posedge System_Clock or posedge System_Reset) begin
    if (System_Reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], Pressure_Raw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Debouncer runs regardless of FSM state. A new level must be seen on
  // DEBOUNCE_CYCLES consecutive edges; any sample equal to db restarts it.
  always_ff @(posedge System_Clock or posedge System_Reset) begin
    if (System_Reset) begin
      db     <= 1'b0;
      db_cnt <= '0;
    end else if (s == db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db     <= s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  // Next-state decode. Pump-off is checked first so a pump drop never
  // produces a fault, and db is checked before the timeout so a rise on
  // the final timeout edge still qualifies.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    case (state)
      ST_IDLE: begin
        if (Pump_ON_Signal) begin
          state_nxt = ST_WAIT_RISE;
          timer_nxt = '0;
        end
      end
      ST_WAIT_RISE: begin
        if (!Pump_ON_Signal) begin
          state_nxt = ST_IDLE;
        end else if (db) begin
          state_nxt = ST_OK;
        end else if (timer == TMR_LAST) begin
          state_nxt = ST_FAULT;
        end else begin
          timer_nxt = timer + CNT_W'(1);
        end
      end
      ST_OK: begin
        if (!Pump_ON_Signal) begin
          state_nxt = ST_IDLE;
        end else if (!db) begin
          state_nxt = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (Fault_Clear && !Pump_ON_Signal) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they move on the same
  // edge as State_Code.
  always_ff @(posedge System_Clock or posedge System_Reset) begin
    if (System_Reset) begin
      state              <= ST_IDLE;
      timer              <= '0;
      Pressure_OK_Signal <= 1'b0;
      Pressure_Fault     <= 1'b0;
    end else begin
      state              <= state_nxt;
      timer              <= timer_nxt;
      Pressure_OK_Signal <= (state_nxt == ST_OK);
      Pressure_Fault     <= (state_nxt == ST_FAULT);
    end
  end

  assign State_Code = state;

endmodule

// File: tb/tb_pressure_ok_qualifier.sv
// tb_pressure_ok_qualifier: directed checks of the pressure qualifier with default parameters.
// Latency: inputs driven 1 time unit after an edge, outputs sampled at the same point.
// Backpressure: not applicable.
module tb_pressure_ok_qualifier;

  logic       clk;
  logic       rst;
  logic       pump;
  logic       raw;
  logic       fclr;
  logic       pressure_ok;
  logic       pressure_fault;
  logic [1:0] state_code;

  int n_checks;
  int n_errors;
  logic saw_ok;

  pressure_ok_qualifier dut (
    .System_Clock       (clk),
    .System_Reset       (rst),
    .Pump_ON_Signal     (pump),
    .Pressure_Raw       (raw),
    .Fault_Clear        (fclr),
    .Pressure_OK_Signal (pressure_ok),
    .Pressure_Fault     (pressure_fault),
    .State_Code         (state_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    saw_ok   = 1'b0;
    rst  = 1'b1;
    pump = 1'b0;
    raw  = 1'b0;
    fclr = 1'b0;

    // Reset state
    tick(3);
    check("rst_state", 32'(state_code), 0);
    check("rst_ok", 32'(pressure_ok), 0);
    check("rst_fault", 32'(pressure_fault), 0);
    rst = 1'b0;
    tick(4);
    check("idle_hold", 32'(state_code), 0);

    // Pump on, then pressure rises: OK 19 edges after raw first sampled high
    pump = 1'b1;
    tick(1);
    check("enter_wait", 32'(state_code), 1);
    tick(3);
    raw = 1'b1;
    tick(18);
    check("rise18_ok", 32'(pressure_ok), 0);
    check("rise18_state", 32'(state_code), 1);
    tick(1);
    check("rise19_ok", 32'(pressure_ok), 1);
    check("rise19_state", 32'(state_code), 2);

    // 15-sample dropout is filtered
    raw = 1'b0;
    tick(15);
    raw = 1'b1;
    tick(30);
    check("glitch15_ok", 32'(pressure_ok), 1);
    check("glitch15_state", 32'(state_code), 2);

    // Sustained loss: FAULT on edge 19, OK falls on the same edge
    raw = 1'b0;
    tick(18);
    check("loss18_ok", 32'(pressure_ok), 1);
    check("loss18_fault", 32'(pressure_fault), 0);
    tick(1);
    check("loss19_ok", 32'(pressure_ok), 0);
    check("loss19_fault", 32'(pressure_fault), 1);
    check("loss19_state", 32'(state_code), 3);

    // Fault_Clear ignored while pump on, honoured with pump off
    fclr = 1'b1;
    tick(3);
    check("clr_pump_on", 32'(state_code), 3);
    pump = 1'b0;
    tick(1);
    check("clr_pump_off_state", 32'(state_code), 0);
    check("clr_pump_off_fault", 32'(pressure_fault), 0);
    fclr = 1'b0;

    // Timeout exactly 1000 edges after WAIT_RISE entry
    pump = 1'b1;
    tick(1);
    check("to_enter", 32'(state_code), 1);
    tick(999);
    check("to_999_state", 32'(state_code), 1);
    check("to_999_fault", 32'(pressure_fault), 0);
    tick(1);
    check("to_1000_fault", 32'(pressure_fault), 1);
    check("to_1000_state", 32'(state_code), 3);
    pump = 1'b0;
    fclr = 1'b1;
    tick(1);
    check("to_clear", 32'(state_code), 0);
    fclr = 1'b0;

    // Raw toggling every 8 edges never qualifies; timeout still on schedule
    pump = 1'b1;
    tick(1);
    check("tog_enter", 32'(state_code), 1);
    for (int i = 0; i < 999; i++) begin
      if (i % 8 == 0) raw = ~raw;
      tick(1);
      if (pressure_ok) saw_ok = 1'b1;
    end
    check("tog_999_state", 32'(state_code), 1);
    tick(1);
    check("tog_1000_fault", 32'(pressure_fault), 1);
    check("tog_never_ok", 32'(saw_ok), 0);
    raw  = 1'b0;
    pump = 1'b0;
    fclr = 1'b1;
    tick(1);
    check("tog_clear", 32'(state_code), 0);
    fclr = 1'b0;
    tick(20);

    // db rise on the timeout edge wins
    pump = 1'b1;
    tick(1);
    tick(981);
    raw = 1'b1;
    tick(18);
    check("race_999_state", 32'(state_code), 1);
    tick(1);
    check("race_1000_state", 32'(state_code), 2);
    check("race_1000_fault", 32'(pressure_fault), 0);

    // Pump drop on the same edge the FSM sees pressure loss: no fault
    raw = 1'b0;
    tick(18);
    check("drop_pre_state", 32'(state_code), 2);
    pump = 1'b0;
    tick(1);
    check("drop_state", 32'(state_code), 0);
    check("drop_fault", 32'(pressure_fault), 0);
    check("drop_ok", 32'(pressure_ok), 0);

    // Async reset mid-WAIT_RISE at timer=500, timer restarts from 0
    pump = 1'b1;
    tick(1);
    tick(500);
    check("mid_wait_state", 32'(state_code), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_state", 32'(state_code), 0);
    check("arst_fault", 32'(pressure_fault), 0);
    #1 rst = 1'b0;
    tick(1);
    check("rearm_enter", 32'(state_code), 1);
    tick(999);
    check("rearm_999_state", 32'(state_code), 1);
    tick(1);
    check("rearm_1000_fault", 32'(pressure_fault), 1);
    pump = 1'b0;
    fclr = 1'b1;
    tick(1);
    fclr = 1'b0;
    check("rearm_clear", 32'(state_code), 0);

    // db already high when the pump starts: OK one edge after WAIT_RISE
    raw = 1'b1;
    tick(25);
    pump = 1'b1;
    tick(1);
    check("pre_db_wait", 32'(state_code), 1);
    tick(1);
    check("pre_db_ok_state", 32'(state_code), 2);
    check("pre_db_ok", 32'(pressure_ok), 1);

    // Async reset from OK clears outputs at once; full latency reapplies
    #2 rst = 1'b1;
    #1;
    check("arst_ok_ok", 32'(pressure_ok), 0);
    check("arst_ok_state", 32'(state_code), 0);
    #1 rst = 1'b0;
    tick(1);
    check("rst_rearm_enter", 32'(state_code), 1);
    tick(17);
    check("rst_rearm18_ok", 32'(pressure_ok), 0);
    check("rst_rearm18_state", 32'(state_code), 1);
    tick(1);
    check("rst_rearm19_ok", 32'(pressure_ok), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pressure_ok_qualifier.md
# pressure_ok_qualifier

Upstream qualifier that produces the `Pressure_OK_Signal` consumed by the safe-startup interlock. It synchronizes and debounces the raw pressure-switch input and arms only while the pump is commanded on. It flags a latched fault if pressure does not build within a timeout, or if pressure is lost while running. `Pressure_OK_Signal` is asserted only in the qualified state, so chatter never reaches the `Master_Start` logic.

## Interface
- `SYNC_STAGES`, 2 — synchronizer flops on `Pressure_Raw`; must be ≥2.
- `DEBOUNCE_CYCLES`, 16 — consecutive clock edges a new synchronized level must persist; must be ≥2.
- `TIMEOUT_CYCLES`, 1000 — edges allowed in WAIT_RISE before fault; must be > `SYNC_STAGES` + `DEBOUNCE_CYCLES` + 1.
- `CNT_W`, 16 — timeout counter width; must hold `TIMEOUT_CYCLES`-1.
- `System_Clock` in 1 — single clock; all state on rising edge.
- `System_Reset` in 1 — asynchronous, active-high reset.
- `Pump_ON_Signal` in 1 — pump run command, synchronous to `System_Clock`.
- `Pressure_Raw` in 1 — raw pressure switch, asynchronous and noisy.
- `Fault_Clear` in 1 — synchronous fault acknowledge.
- `Pressure_OK_Signal` out 1 — registered; 1 only in state OK.
- `Pressure_Fault` out 1 — registered; 1 only in state FAULT.
- `State_Code` out 2 — IDLE=00, WAIT_RISE=01, OK=10, FAULT=11.

## Operation
- Reset: sync flops=0, debounced level `db`=0, debounce count=0, timer=0, state IDLE. All outputs are 0 and `State_Code`=00.
- Synchronizer: `s` equals `Pressure_Raw` delayed by `SYNC_STAGES` edges.
- Debounce, per edge:
  - If `s`==`db`, count←0.
  - Otherwise, if count==`DEBOUNCE_CYCLES`-1, then `db`←`s` and count←0; else count←count+1.
  - A single matching sample restarts the count.
- The debouncer runs in every state, independent of the FSM.
- FSM, evaluated each edge with fixed priority:
  - IDLE: `Pump_ON_Signal`=1 → WAIT_RISE, timer←0.
  - WAIT_RISE: `Pump_ON_Signal`=0 → IDLE; else `db`=1 → OK; else timer==`TIMEOUT_CYCLES`-1 → FAULT; else timer←timer+1.
  - OK: `Pump_ON_Signal`=0 → IDLE; else `db`=0 → FAULT (pressure loss while running).
  - FAULT: `Fault_Clear`=1 and `Pump_ON_Signal`=0 → IDLE; otherwise hold. `Fault_Clear` with the pump on is ignored.
- Outputs are registered from the next-state decode, so they change on the same edge as `State_Code`.
- The timer is held (not counting) outside WAIT_RISE and saturates at no value beyond `TIMEOUT_CYCLES`-1.

## Timing
- Rise latency: `Pressure_Raw` rises stable before edge 1 with the FSM in WAIT_RISE.
  - `s` rises at edge `SYNC_STAGES`.
  - `db` rises at edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`.
  - `Pressure_OK_Signal` rises at edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`+1. With defaults this is edge 19.
- Fall latency from OK: the same count. `Pressure_OK_Signal` falls and `Pressure_Fault` rises on the same edge.
- Timeout: counting from the edge that enters WAIT_RISE, FAULT is entered exactly `TIMEOUT_CYCLES` edges later.
- Pump drop: one edge from `Pump_ON_Signal`=0 to IDLE. `Pressure_OK_Signal` falls on that edge.
- Simultaneous `db` rise and timeout edge: `db` wins and the FSM goes to OK.
- Pump drop coinciding with timeout or pressure loss: the FSM goes to IDLE with no fault.
- `db` already 1 when the pump starts: IDLE→WAIT_RISE on edge n, OK on edge n+1.
- Reset mid-operation: outputs clear asynchronously. After release, the FSM restarts from IDLE with `db`=0, so full debounce latency reapplies.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronized samples never changes `db`.

## Test plan
- Reset, pump on at edge 5, `Pressure_Raw` held 1 from edge 10 → `State_Code`=01 after edge 6; `Pressure_OK_Signal`=1 first after edge 10+19=29.
- Pump on, `Pressure_Raw` held 0 → `Pressure_Fault`=1 exactly 1000 edges after WAIT_RISE entry. `Fault_Clear` with pump on is ignored. Pump off plus `Fault_Clear` → IDLE next edge.
- In OK, `Pressure_Raw` pulses 0 for 15 synchronized cycles → OK is held. A drop held for 16 cycles → FAULT on edge 19 after the drop.
- In WAIT_RISE, `Pressure_Raw` toggles every 8 cycles → never OK; timeout fault fires on schedule.
- In OK, pump drops on the same edge `db` falls → IDLE, `Pressure_Fault` stays 0.
- `System_Reset` asserted mid-WAIT_RISE with timer=500 → outputs 0 immediately. Re-arming requires the full 19-edge latency, and the timer restarts from 0.
